// File: rtl/spc_pcx_pkg.sv
// Shared PCX request-side constants: destination encodings, widths, credit depth.
package spc_pcx_pkg;

  localparam int NUM_DEST = 5;
  localparam int PCX_W    = 124;
  localparam int CREDITS  = 2;

  localparam logic [NUM_DEST-1:0] DEST_L2B0 = 5'b00001;
  localparam logic [NUM_DEST-1:0] DEST_L2B1 = 5'b00010;
  localparam logic [NUM_DEST-1:0] DEST_L2B2 = 5'b00100;
  localparam logic [NUM_DEST-1:0] DEST_L2B3 = 5'b01000;
  localparam logic [NUM_DEST-1:0] DEST_IOFP = 5'b10000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ATOM2 = 1'b1
  } sched_state_e;

  function automatic logic is_onehot(input logic [NUM_DEST-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/spc_pcx_rr_arb.sv
// Generic round-robin arbiter; the pointer moves to adv_idx+1 when adv is pulsed.
module spc_pcx_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [NREQ-1:0] elig,
  input  logic            adv,
  input  logic [IW-1:0]   adv_idx,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            vld
);

  logic [IW-1:0] ptr;

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!vld && elig[j]) begin
        vld      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l)
      ptr <= '0;
    else if (adv)
      ptr <= (int'(adv_idx) == NREQ - 1) ? '0 : adv_idx + 1'b1;
  end

endmodule

// File: rtl/spc_pcx_req_sched.sv
// Per-core PCX request scheduler: credit tracking, round-robin issue, CAS pair sequencing.
// Define SPC_PCX_SCHED_ERR_EN to add the sticky sched_err output.
//
// state    | meaning
// ST_IDLE  | arbitrate among eligible requesters, issue one packet
// ST_ATOM2 | reissue second CAS packet for the latched requester/destination
module spc_pcx_req_sched #(
  parameter int NREQ    = 4,
  parameter int PCX_W   = spc_pcx_pkg::PCX_W,
  parameter int CREDITS = spc_pcx_pkg::CREDITS
) (
  input  logic                  rclk,
  input  logic                  rst_l,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ*5-1:0]     req_dest,
  input  logic [NREQ-1:0]       req_atom,
  input  logic [NREQ*PCX_W-1:0] req_data,
  output logic [NREQ-1:0]       req_ack,
  output logic [4:0]            spc_pcx_req_pq,
  output logic                  spc_pcx_atom_pq,
  output logic [PCX_W-1:0]      spc_pcx_data_pa,
  input  logic [4:0]            pcx_spc_grant_px
`ifdef SPC_PCX_SCHED_ERR_EN
  ,
  output logic                  sched_err
`endif
);

  import spc_pcx_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  logic [NUM_DEST-1:0] dest [NREQ];
  logic [NREQ-1:0]     elig;
  logic [CW-1:0]       cred [NUM_DEST];
  sched_state_e        state;
  logic [IW-1:0]       atom_idx;
  logic [NUM_DEST-1:0] atom_dest;
  logic [NREQ-1:0]     win_gnt;
  logic [IW-1:0]       win_idx;
  logic                win_vld;
  logic [IW-1:0]       sel_idx;
  logic                adv;
  logic [NUM_DEST-1:0] issue;

  // An atomic needs room for both packets before the first one goes out.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      dest[i] = req_dest[i*NUM_DEST +: NUM_DEST];
      elig[i] = 1'b0;
      if (req_vld[i] && is_onehot(dest[i])) begin
        for (int d = 0; d < NUM_DEST; d++) begin
          if (dest[i][d] && (cred[d] >= (req_atom[i] ? CW'(2) : CW'(1))))
            elig[i] = 1'b1;
        end
      end
    end
  end

  spc_pcx_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk     (rclk),
    .rst_l   (rst_l),
    .elig    (state == ST_IDLE ? elig : '0),
    .adv     (adv),
    .adv_idx (sel_idx),
    .grant   (win_gnt),
    .idx     (win_idx),
    .vld     (win_vld)
  );

  // Outputs are held low while reset is asserted so a pending ATOM2 never leaks out.
  always_comb begin
    req_ack         = '0;
    spc_pcx_req_pq  = '0;
    spc_pcx_atom_pq = 1'b0;
    sel_idx         = win_idx;
    adv             = 1'b0;
    if (rst_l) begin
      if (state == ST_ATOM2) begin
        req_ack[atom_idx] = 1'b1;
        spc_pcx_req_pq    = atom_dest;
        sel_idx           = atom_idx;
        adv               = 1'b1;
      end else if (win_vld) begin
        req_ack         = win_gnt;
        spc_pcx_req_pq  = dest[win_idx];
        spc_pcx_atom_pq = req_atom[win_idx];
        adv             = !req_atom[win_idx];
      end
    end
  end

  assign issue = spc_pcx_req_pq;

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      state           <= ST_IDLE;
      atom_idx        <= '0;
      atom_dest       <= '0;
      spc_pcx_data_pa <= '0;
    end else begin
      if (|issue)
        spc_pcx_data_pa <= req_data[int'(sel_idx)*PCX_W +: PCX_W];
      case (state)
        ST_IDLE: begin
          if (win_vld && req_atom[win_idx]) begin
            state     <= ST_ATOM2;
            atom_idx  <= win_idx;
            atom_dest <= dest[win_idx];
          end
        end
        ST_ATOM2: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Grant at full credit saturates instead of wrapping.
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      for (int d = 0; d < NUM_DEST; d++) cred[d] <= CW'(CREDITS);
    end else begin
      for (int d = 0; d < NUM_DEST; d++) begin
        case ({issue[d], pcx_spc_grant_px[d]})
          2'b10:   cred[d] <= cred[d] - 1'b1;
          2'b01:   if (cred[d] != CW'(CREDITS)) cred[d] <= cred[d] + 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef SPC_PCX_SCHED_ERR_EN
  logic [NREQ-1:0]     bad_now;
  logic [NREQ-1:0]     bad_prev;
  logic [NUM_DEST-1:0] full;

  always_comb begin
    for (int i = 0; i < NREQ; i++) bad_now[i] = req_vld[i] && !is_onehot(dest[i]);
    for (int d = 0; d < NUM_DEST; d++) full[d] = (cred[d] == CW'(CREDITS));
  end

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      sched_err <= 1'b0;
      bad_prev  <= '0;
    end else begin
      bad_prev <= bad_now;
      if ((|(pcx_spc_grant_px & ~issue & full)) || (|(bad_now & bad_prev)))
        sched_err <= 1'b1;
    end
  end
`endif

endmodule
